imem_port_arbiter: RTL
======================

// Module: imem_port_arbiter
// PURPOSE
//  Shares one single-port synchronous instruction memory (1-cycle read latency) between the
//  CPU fetch stage and a program loader (UART/debug) that reads and writes program words.
//  Sits between the fetch stage, the loader and imem.
//  A RUN/LOAD state machine freezes fetch during a program download; a starvation counter
//  guarantees loader progress while the CPU is running.
// PARAMETERS
//  ADDR_W      16  word-address width to memory; mem_addr = byte_addr[ADDR_W+1:2]
//  STARVE_MAX  4   consecutive denied loader-request cycles in RUN before loader wins (>=1)
// PORTS
//  clk        in   1       clock, all state on posedge
//  rst        in   1       synchronous reset, active-high
//  if_req     in   1       fetch read request
//  if_addr    in   32      fetch byte address
//  if_gnt     out  1       fetch granted this cycle (combinational)
//  if_rvalid  out  1       fetch read data valid (cycle after grant)
//  if_rdata   out  32      fetch read data
//  ld_lock    in   1       loader owns memory exclusively (program download)
//  ld_req     in   1       loader request
//  ld_we      in   1       loader write (1) / read (0)
//  ld_addr    in   32      loader byte address
//  ld_wdata   in   32      loader write data
//  ld_gnt     out  1       loader granted this cycle (combinational)
//  ld_rvalid  out  1       loader read data valid (cycle after read grant)
//  ld_rdata   out  32      loader read data
//  cpu_hold   out  1       stall/hold request to the CPU pipeline (registered)
//  mem_en     out  1       memory access enable
//  mem_we     out  1       memory write enable
//  mem_addr   out  ADDR_W  memory word address
//  mem_wdata  out  32      memory write data
//  mem_rdata  in   32      memory read data, valid 1 cycle after mem_en & !mem_we
// BEHAVIOUR
//  - FSM states RUN (reset state) and LOAD, each transition takes effect on the next clock:
//    RUN->LOAD when ld_lock=1; LOAD->RUN when ld_lock=0. cpu_hold = (state==LOAD).
//  - LOAD: if_gnt=0 always; ld_gnt=ld_req. starv_cnt held at 0.
//  - RUN: fetch has priority. ld_gnt = ld_req & (!if_req | starv_cnt==STARVE_MAX);
//    if_gnt = if_req & !ld_gnt. At most one grant per cycle.
//  - starv_cnt: +1 when ld_req & !ld_gnt in RUN (saturates at STARVE_MAX);
//    cleared on ld_gnt or !ld_req.
//  - mem_en = if_gnt|ld_gnt. mem_we = ld_gnt&ld_we. mem_addr/mem_wdata come from the
//    granted side. With no grant: mem_addr=0 and mem_wdata=0.
//  - Fetch never writes. Byte addr[1:0] ignored; addr bits above ADDR_W+1 ignored.
//  - if_rvalid/ld_rvalid: registered copies of (if_gnt) / (ld_gnt & !ld_we); pulse exactly
//    1 cycle later. if_rdata = ld_rdata = mem_rdata (qualify with rvalid).
//  - Back-to-back grants permitted every cycle; read-after-write to the same address on the
//    next cycle returns the new data (memory write-first is the memory's contract).
//  - Simultaneous ld_lock rise and if_req in RUN: this cycle still arbitrates as RUN; fetch
//    blocked from the next cycle on. An in-flight read still returns its rvalid after the
//    state change.
//  - Reset (any cycle): state=RUN, starv_cnt=0, if_rvalid=ld_rvalid=0, cpu_hold=0. A read
//    granted in the reset cycle produces no rvalid. Grants are forced 0 while rst=1.
// CONFIGURATION
//  IMEM_ARB_STATS_EN defined: adds ports
//    stat_if_stall out 32  cycles with if_req & !if_gnt
//    stat_ld_wr    out 32  granted loader writes
//  Both counters saturate at 32'hFFFFFFFF and are cleared by rst.
//  IMEM_ARB_STATS_EN undefined: ports and counters absent; arbitration identical.
// TESTING
//  1 rst, if_req=1 addr 0x0 then 0x4 -> if_gnt=1 both cycles, if_rvalid on the 2 following cycles,
//    mem_addr 0x0000 then 0x0001.
//  2 RUN: if_req and ld_req held 1, STARVE_MAX=4 -> ld_gnt only on 5th cycle, then 4 fetch
//    grants, repeating; starv_cnt never exceeds 4.
//  3 ld_lock=1, write 0x000020b7 @0x0 and 0x70f08093 @0x4, if_req=1 -> if_gnt=0, cpu_hold=1;
//    loader read @0x4 -> ld_rvalid, ld_rdata=0x70f08093.
//  4 ld_lock 1->0 with if_req=1 -> cpu_hold drops next cycle, if_gnt=1 that cycle;
//    pending loader read rvalid still delivered.
//  5 rst asserted in cycle after if_gnt -> if_rvalid=0, cpu_hold=0, state RUN;
//    no stray rvalid afterwards.
//  6 IMEM_ARB_STATS_EN: 3 stalled fetch cycles and 2 loader writes -> stat_if_stall=3,
//    stat_ld_wr=2; rst -> both 0.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one single-port sync imem (1-cycle read) between
// CPU fetch and a program loader; RUN/LOAD FSM plus loader starvation guard.
// Optional macro IMEM_ARB_STATS_EN adds stat_if_stall / stat_ld_wr counters.
// Ports: clk, rst (sync, active-high);
//   fetch:  if_req, if_addr -> if_gnt, if_rvalid, if_rdata
//   loader: ld_lock, ld_req, ld_we, ld_addr, ld_wdata
//           -> ld_gnt, ld_rvalid, ld_rdata
//   cpu_hold (registered, high in LOAD)
//   memory: mem_en, mem_we, mem_addr, mem_wdata <- mem_rdata
module imem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              ld_lock,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [31:0]       ld_addr,
  input  logic [31:0]       ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [31:0]       ld_rdata,
  output logic              cpu_hold,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_if_stall,
  output logic [31:0]       stat_ld_wr
`endif
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  typedef enum logic {RUN, LOAD} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] starv_q, starv_d;
  logic          if_rv_q, ld_rv_q, hold_q;
  logic          is_run, starved;

  assign is_run  = (state_q == RUN);
  assign starved = (starv_q == SMAX);

  // Fetch wins in RUN unless the loader has been
  // denied STARVE_MAX cycles in a row.
  always_comb begin
    ld_gnt = 1'b0;
    if_gnt = 1'b0;
    if (!rst) begin
      if (is_run) begin
        ld_gnt = ld_req & (~if_req | starved);
        if_gnt = if_req & ~ld_gnt;
      end else begin
        ld_gnt = ld_req;
      end
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (ld_gnt) begin
      mem_addr  = ld_addr[ADDR_W+1:2];
      mem_wdata = ld_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr[ADDR_W+1:2];
    end
  end

  assign mem_en = if_gnt | ld_gnt;
  assign mem_we = ld_gnt & ld_we;

  always_comb begin
    state_d = ld_lock ? LOAD : RUN;
    starv_d = '0;
    if (is_run && ld_req && !ld_gnt)
      starv_d = starved ? starv_q : starv_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      starv_q <= '0;
      if_rv_q <= 1'b0;
      ld_rv_q <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      starv_q <= starv_d;
      if_rv_q <= if_gnt;
      ld_rv_q <= ld_gnt & ~ld_we;
      hold_q  <= (state_d == LOAD);
    end
  end

  assign if_rvalid = if_rv_q;
  assign ld_rvalid = ld_rv_q;
  assign cpu_hold  = hold_q;
  assign if_rdata  = mem_rdata;
  assign ld_rdata  = mem_rdata;

`ifdef IMEM_ARB_STATS_EN
  logic [31:0] stall_q, wr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      wr_q    <= '0;
    end else begin
      if (if_req && !if_gnt && stall_q != '1)
        stall_q <= stall_q + 32'd1;
      if (ld_gnt && ld_we && wr_q != '1)
        wr_q <= wr_q + 32'd1;
    end
  end

  assign stat_if_stall = stall_q;
  assign stat_ld_wr    = wr_q;
`endif

  // Byte-offset and high address bits are ignored.
  logic unused_addr;
  assign unused_addr = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                         ld_addr[31:ADDR_W+2], ld_addr[1:0]};

endmodule
